// File: rtl/sloc_adc_responder.sv
// sloc_adc_responder: slave end of the RFS/TFS/SCLK serial ADC link.
// Accepts control words on TFS frames and returns per-channel sample words
// on RFS frames, so the ADC data-control master can run without a converter.
module sloc_adc_responder #(
  parameter int W           = 16,
  parameter int SAMPLE_W    = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_clk,
  input  logic                reset_n,
  input  logic                sclk,
  input  logic                rfs,
  input  logic                tfs,
  input  logic                din,
  output logic                dout,
  output logic                dout_oe,
  input  logic [SAMPLE_W-1:0] ch0,
  input  logic [SAMPLE_W-1:0] ch1,
  input  logic [SAMPLE_W-1:0] ch2,
  input  logic [SAMPLE_W-1:0] ch3,
  output logic [1:0]          sel_ch,
  output logic [W-1:0]        ctrl_word,
  output logic                ctrl_valid,
  output logic                frame_err
);

  localparam int CNT_W = $clog2(W + 1);

  typedef enum logic { RX_IDLE, RX_SHIFT } rx_state_t;
  typedef enum logic { TX_IDLE, TX_SHIFT } tx_state_t;

  // Synchronizers and previous-value registers for edge detection
  logic [SYNC_STAGES-1:0] sclk_sync, rfs_sync, tfs_sync, din_sync;
  logic                   sclk_d, rfs_d, tfs_d;
  logic                   sclk_s, rfs_s, tfs_s, din_s;
  logic                   sclk_rise, sclk_fall, rfs_fall, rfs_rise, tfs_fall, tfs_rise;

  // Frame syncs reset low so a frame already in progress at reset release
  // produces no falling edge and is therefore ignored.
  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      rfs_sync  <= '0;
      tfs_sync  <= '0;
      din_sync  <= '0;
      sclk_d    <= 1'b0;
      rfs_d     <= 1'b0;
      tfs_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      rfs_sync  <= {rfs_sync[SYNC_STAGES-2:0], rfs};
      tfs_sync  <= {tfs_sync[SYNC_STAGES-2:0], tfs};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      rfs_d     <= rfs_sync[SYNC_STAGES-1];
      tfs_d     <= tfs_sync[SYNC_STAGES-1];
    end
  end

  // Edge detection on the last two synchronized values
  always_comb begin
    sclk_s    = sclk_sync[SYNC_STAGES-1];
    rfs_s     = rfs_sync[SYNC_STAGES-1];
    tfs_s     = tfs_sync[SYNC_STAGES-1];
    din_s     = din_sync[SYNC_STAGES-1];
    sclk_rise = sclk_s & ~sclk_d;
    sclk_fall = ~sclk_s & sclk_d;
    rfs_fall  = ~rfs_s & rfs_d;
    rfs_rise  = rfs_s & ~rfs_d;
    tfs_fall  = ~tfs_s & tfs_d;
    tfs_rise  = tfs_s & ~tfs_d;
  end

  // ---------------- RX path (TFS) ----------------
  rx_state_t        rx_state, rx_next;
  logic [CNT_W-1:0] rx_cnt;
  // Holds the first W-1 bits; the W-th bit goes straight into ctrl_word.
  logic [W-2:0]     rx_sr;
  logic             rx_start, rx_shift, rx_done, rx_err;

  // RX state register
  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n) rx_state <= RX_IDLE;
    else          rx_state <= rx_next;
  end

  // RX next-state logic
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (tfs_fall) rx_next = RX_SHIFT;
      RX_SHIFT: if (tfs_rise || (sclk_rise && rx_cnt == CNT_W'(W - 1))) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // RX control decode
  always_comb begin
    rx_start = (rx_state == RX_IDLE) && tfs_fall;
    rx_shift = (rx_state == RX_SHIFT) && sclk_rise && !tfs_rise;
    rx_done  = rx_shift && (rx_cnt == CNT_W'(W - 1));
    rx_err   = (rx_state == RX_SHIFT) && tfs_rise && (rx_cnt != '0);
  end

  // RX datapath: bit counter, shift register and control word capture
  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_cnt    <= '0;
      rx_sr     <= '0;
      ctrl_word <= '0;
      sel_ch    <= '0;
    end else begin
      if (rx_start) begin
        rx_cnt <= '0;
      end else if (rx_shift) begin
        rx_cnt <= rx_cnt + 1'b1;
        rx_sr  <= {rx_sr[W-3:0], din_s};
      end
      if (rx_done) begin
        ctrl_word <= {rx_sr, din_s};
        sel_ch    <= rx_sr[W-2:W-3];
      end
    end
  end

  // ---------------- TX path (RFS) ----------------
  tx_state_t        tx_state, tx_next;
  logic [CNT_W-1:0] tx_cnt, tx_rcnt;
  logic [W-1:0]     tx_sr, tx_load;
  logic [SAMPLE_W-1:0] ch_pick;
  logic             tx_start, tx_shift, tx_rise, tx_end, tx_err;

  // TX state register
  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n) tx_state <= TX_IDLE;
    else          tx_state <= tx_next;
  end

  // TX next-state logic
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (rfs_fall) tx_next = TX_SHIFT;
      TX_SHIFT: if (rfs_rise) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // TX control decode and sample word assembly
  always_comb begin
    tx_start = (tx_state == TX_IDLE) && rfs_fall;
    tx_end   = (tx_state == TX_SHIFT) && rfs_rise;
    tx_shift = (tx_state == TX_SHIFT) && sclk_fall && !rfs_rise && (tx_cnt != CNT_W'(W));
    tx_rise  = (tx_state == TX_SHIFT) && sclk_rise && (tx_rcnt != CNT_W'(W));
    tx_err   = tx_end && (tx_rcnt != CNT_W'(W));
    case (sel_ch)
      2'd0:    ch_pick = ch0;
      2'd1:    ch_pick = ch1;
      2'd2:    ch_pick = ch2;
      default: ch_pick = ch3;
    endcase
    tx_load = W'({sel_ch, 3'b000, ch_pick});
  end

  // TX datapath: shift register, fall counter and master-rise counter
  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_sr   <= '0;
      tx_cnt  <= '0;
      tx_rcnt <= '0;
    end else if (tx_start) begin
      tx_sr   <= tx_load;
      tx_cnt  <= '0;
      tx_rcnt <= '0;
    end else if (tx_end) begin
      tx_sr   <= '0;
    end else begin
      if (tx_shift) begin
        tx_sr  <= {tx_sr[W-2:0], 1'b0};
        tx_cnt <= tx_cnt + 1'b1;
      end
      if (tx_rise) tx_rcnt <= tx_rcnt + 1'b1;
    end
  end

  assign dout    = tx_sr[W-1];
  assign dout_oe = (tx_state == TX_SHIFT);

  // Status pulses; simultaneous RX and TX errors merge into one pulse
  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      ctrl_valid <= rx_done;
      frame_err  <= rx_err | tx_err;
    end
  end

endmodule

// File: tb/tb_sloc_adc_responder.sv
// Directed testbench for sloc_adc_responder: acts as the serial master.
module tb_sloc_adc_responder;

  localparam int HP = 220;  // SCLK half period (~2.27 MHz), multiple of clk period

  logic        clk_clk = 1'b0;
  logic        reset_n;
  logic        sclk, rfs, tfs, din;
  logic        dout, dout_oe;
  logic [10:0] ch0, ch1, ch2, ch3;
  logic [1:0]  sel_ch;
  logic [15:0] ctrl_word;
  logic        ctrl_valid, frame_err;

  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  int nerr   = 0;

  sloc_adc_responder #(.W(16), .SAMPLE_W(11), .SYNC_STAGES(2)) dut (
    .clk_clk    (clk_clk),
    .reset_n    (reset_n),
    .sclk       (sclk),
    .rfs        (rfs),
    .tfs        (tfs),
    .din        (din),
    .dout       (dout),
    .dout_oe    (dout_oe),
    .ch0        (ch0),
    .ch1        (ch1),
    .ch2        (ch2),
    .ch3        (ch3),
    .sel_ch     (sel_ch),
    .ctrl_word  (ctrl_word),
    .ctrl_valid (ctrl_valid),
    .frame_err  (frame_err)
  );

  always #10 clk_clk = ~clk_clk;

  always @(posedge clk_clk) begin
    if (ctrl_valid) nvalid++;
    if (frame_err)  nerr++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One master frame with shared SCLK; either or both frame syncs low.
  task automatic xfer(input logic [15:0] word, input bit use_tfs, input bit use_rfs,
                      input int n, output logic [15:0] rd, output bit oe_ok);
    rd    = '0;
    oe_ok = 1'b1;
    if (use_tfs) tfs = 1'b0;
    if (use_rfs) rfs = 1'b0;
    #HP;
    for (int i = 0; i < n; i++) begin
      din = word[15-i];
      #HP;
      sclk = 1'b1;
      if (use_rfs) begin
        rd = {rd[14:0], dout};
        if (dout_oe !== 1'b1) oe_ok = 1'b0;
      end
      #HP;
      sclk = 1'b0;
    end
    #HP;
    tfs = 1'b1;
    rfs = 1'b1;
    din = 1'b0;
    #(4*HP);
  endtask

  logic [15:0] rd;
  bit          ok;
  int          v0, e0;

  initial begin
    reset_n = 1'b0;
    sclk = 1'b0; rfs = 1'b1; tfs = 1'b1; din = 1'b0;
    ch0 = 11'h123; ch1 = 11'h7FF; ch2 = 11'h5A3; ch3 = 11'h2AB;
    #100;
    check("rst_dout", dout, 0);
    check("rst_oe", dout_oe, 0);
    check("rst_sel", sel_ch, 0);
    check("rst_ctrl", ctrl_word, 0);
    check("rst_valid", ctrl_valid, 0);
    check("rst_err", frame_err, 0);
    reset_n = 1'b1;
    #200;

    // Control word 8000 selects channel 2
    v0 = nvalid; e0 = nerr;
    xfer(16'h8000, 1, 0, 16, rd, ok);
    check("t1_valid_cnt", nvalid - v0, 1);
    check("t1_ctrl", ctrl_word, 16'h8000);
    check("t1_sel", sel_ch, 2);
    check("t1_err_cnt", nerr - e0, 0);

    // Sample read from channel 2
    check("t2_oe_before", dout_oe, 0);
    e0 = nerr;
    xfer(16'h0000, 0, 1, 16, rd, ok);
    check("t2_word", rd, 16'h85A3);
    check("t2_oe_inside", ok, 1);
    check("t2_oe_after", dout_oe, 0);
    check("t2_err_cnt", nerr - e0, 0);

    // Channel 1 = -1, sign bits preserved
    xfer(16'h4000, 1, 0, 16, rd, ok);
    check("t3_sel", sel_ch, 1);
    xfer(16'h0000, 0, 1, 16, rd, ok);
    check("t3_word", rd, 16'h47FF);

    // Short TFS frame: 9 clocks then tfs rises
    v0 = nvalid; e0 = nerr;
    xfer(16'hFFFF, 1, 0, 9, rd, ok);
    check("t4_err_cnt", nerr - e0, 1);
    check("t4_valid_cnt", nvalid - v0, 0);
    check("t4_sel", sel_ch, 1);
    check("t4_ctrl", ctrl_word, 16'h4000);

    // Empty TFS frame: no error
    e0 = nerr;
    xfer(16'hFFFF, 1, 0, 0, rd, ok);
    check("t4_empty_err", nerr - e0, 0);

    // Short RFS frame: 5 clocks
    e0 = nerr;
    xfer(16'h0000, 0, 1, 5, rd, ok);
    check("t4_rfs_short_err", nerr - e0, 1);

    // Simultaneous short RX and TX frames: single error pulse
    e0 = nerr;
    xfer(16'h0000, 1, 1, 5, rd, ok);
    check("t4_dual_err", nerr - e0, 1);
    check("t4_dual_sel", sel_ch, 1);

    // Select channel 0, then overlapping TFS (C000) + RFS
    xfer(16'h0000, 1, 0, 16, rd, ok);
    check("t5_sel0", sel_ch, 0);
    e0 = nerr;
    xfer(16'hC000, 1, 1, 16, rd, ok);
    check("t5_overlap_word", rd, 16'h0123);
    check("t5_sel3", sel_ch, 3);
    check("t5_ctrl", ctrl_word, 16'hC000);
    check("t5_err_cnt", nerr - e0, 0);
    xfer(16'h0000, 0, 1, 16, rd, ok);
    check("t5_next_word", rd, 16'hC2AB);

    // Reset during an RFS frame at SCLK 7 (word C2AB, 7th bit is 1)
    rfs = 1'b0;
    #HP;
    for (int i = 0; i < 7; i++) begin
      #HP; sclk = 1'b1;
      if (i < 6) begin #HP; sclk = 1'b0; end
    end
    check("t6_oe_mid", dout_oe, 1);
    check("t6_dout_mid", dout, 1);
    reset_n = 1'b0;
    #1;
    check("t6_dout_rst", dout, 0);
    check("t6_oe_rst", dout_oe, 0);
    #19;
    #40;
    reset_n = 1'b1;
    #(HP-60);
    sclk = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #HP; sclk = 1'b1;
      if (dout_oe !== 1'b0 || dout !== 1'b0) ok = 1'b0;
      #HP; sclk = 1'b0;
      if (dout_oe !== 1'b0 || dout !== 1'b0) ok = 1'b0;
    end
    check("t6_quiet_after", ok, 1);
    rfs = 1'b1;
    #(4*HP);
    check("t6_sel_after", sel_ch, 0);
    check("t6_ctrl_after", ctrl_word, 0);
    xfer(16'h0000, 0, 1, 16, rd, ok);
    check("t6_next_word", rd, 16'h0123);
    check("t6_next_oe", ok, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sloc_adc_responder.md
Name: sloc_adc_responder

Overview:
- Synthesizable serial-ADC responder: the slave end of the RFS/TFS/SCLK serial link driven by the ADC data-control master.
- Receives 16-bit control words on the TFS frame.
- Returns 16-bit sample words on the RFS frame for the selected channel, using per-channel sample inputs.
- Used for on-board loopback and emulation of the ADC, so the master, channel registers and FIR path can be exercised without the converter fitted.

Parameters:
- W, 16, bits per serial frame (control and sample words).
- SAMPLE_W, 11, width of each signed channel sample.
- SYNC_STAGES, 2, synchronizer depth on all serial input pins.

Ports:
- clk_clk  input  1  system clock (CLOCK_50 domain); must be at least 8x the SCLK frequency.
- reset_n  input  1  asynchronous active-low reset.
- sclk  input  1  serial clock from master, asynchronous to clk_clk.
- rfs  input  1  receive frame sync, active low; master reads a sample word.
- tfs  input  1  transmit frame sync, active low; master writes a control word.
- din  input  1  serial data from master (master SPI_OUT).
- dout  output  1  serial data to master (master SPI_IN).
- dout_oe  output  1  high while an RFS frame is active.
- ch0..ch3  input  SAMPLE_W each  signed sample values presented per channel.
- sel_ch  output  2  channel currently selected by the last valid control word.
- ctrl_word  output  W  last complete control word.
- ctrl_valid  output  1  one-cycle pulse when ctrl_word updates.
- frame_err  output  1  one-cycle pulse on a short frame (RX or TX).

Behaviour:
- Input capture:
  - sclk, rfs, tfs and din each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last two synchronized values.
  - All pin-to-internal latency is SYNC_STAGES+1 clk_clk cycles.
- Bit timing:
  - The master samples on SCLK rising edges; the responder samples din on synchronized SCLK rising edges.
  - The responder updates dout on synchronized SCLK falling edges.
  - All data is MSB first.
- RX path (TFS):
  - States RX_IDLE and RX_SHIFT.
  - The synchronized tfs falling edge enters RX_SHIFT and clears rx_cnt.
  - Each SCLK rise while in RX_SHIFT shifts din into rx_sr and increments rx_cnt.
  - When rx_cnt reaches W:
    - ctrl_word <= rx_sr.
    - sel_ch <= rx_sr[W-1:W-2].
    - ctrl_valid pulses in the cycle after the W-th rise.
    - The FSM returns to RX_IDLE.
  - Further SCLK edges while tfs stays low are ignored.
  - If tfs rises with 0 < rx_cnt < W: frame_err pulses, the word is discarded, and sel_ch and ctrl_word are unchanged.
  - If tfs rises with rx_cnt == 0: no error, no effect.
- TX path (RFS):
  - States TX_IDLE and TX_SHIFT.
  - On the synchronized rfs falling edge, tx_sr is loaded with {sel_ch, 3'b000, ch[sel_ch]}, where the channel sample is snapshotted in that cycle. The word layout is fixed for W=16 and SAMPLE_W=11.
  - dout = tx_sr[W-1] immediately; dout_oe = 1; tx_cnt = 0.
  - Each SCLK fall shifts tx_sr left, filling with 0, and increments tx_cnt.
  - After W-1 shifts, dout holds bit 0 until the frame ends; further falls drive 0.
  - If rfs rises before W SCLK rises are seen: frame_err pulses.
  - On any rfs rise: dout_oe = 0, dout = 0, TX_IDLE.
- Concurrency and simultaneous events:
  - RX and TX are independent and may overlap (full duplex).
  - A control word completing during a TX frame does not alter the in-flight sample; the new sel_ch applies from the next RFS frame.
  - An RX error and a TX error in the same cycle produce a single frame_err pulse.
- Reset (asynchronous, any time, including mid-frame):
  - dout = 0, dout_oe = 0, sel_ch = 0, ctrl_word = 0, ctrl_valid = 0, frame_err = 0.
  - Both FSMs return to idle and all counters and shift registers are cleared.
  - A frame already in progress at reset release is not recognised; the responder waits for the next falling frame-sync edge.

Test Plan:
- Reset, then TFS frame with din word 16'h8000 at SCLK = 2.27 MHz -> ctrl_valid pulses once; ctrl_word = 16'h8000; sel_ch = 2.
- sel_ch = 2, ch2 = 11'sh5A3, RFS frame of 16 clocks -> master shifts in 16'h85A3; dout_oe high only inside the frame.
- ch1 = -1 (11'h7FF), control word 16'h4000 then RFS frame -> received word 16'h47FF; sign bits intact.
- TFS raised after 9 SCLKs -> frame_err one pulse; sel_ch and ctrl_word unchanged from the prior value.
- Overlapping TFS (word 16'hC000) and RFS frames with sel_ch = 0 and ch0 = 11'sh123 -> RFS returns 16'h0123; the next RFS returns {2'b11, 3'b000, ch3}.
- reset_n asserted at SCLK 7 of an RFS frame -> dout and dout_oe drop to 0 asynchronously; after release, no output until the next rfs falling edge.
